fetch_unit: RTL



---
 rtl/fetch_pkg.sv | 10 +
 rtl/fetch_unit.sv | 93 +++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int          INSTR_W  = 32;
  localparam logic [31:0] PC_STEP  = 32'd4;
  localparam logic [31:0] DEF_NOP  = 32'h0000_0000;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_FULL, S_DRAIN} fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the fetch PC and runs a single-outstanding imem handshake,
// with a one-entry skid for responses that land while the output slot is stalled.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = DEF_NOP
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               StallF,
  input  logic               BranchTakenE,
  input  logic [31:0]        BranchTargetE,
  output logic               ImemReq,
  output logic [31:0]        ImemAddr,
  input  logic               ImemGnt,
  input  logic               ImemRValid,
  input  logic [INSTR_W-1:0] ImemRData,
  output logic [INSTR_W-1:0] InstrF,
  output logic               InstrValidF,
  output logic [31:0]        PCF,
  output logic [31:0]        PCPlus4F
);

  fetch_state_t        state;
  logic [31:0]         fpc;
  logic [INSTR_W-1:0]  sk_instr;
  logic [31:0]         sk_pc;
  logic                sk_v;
  logic                slot_free;

  // Request decode depends on registered state only; reset masks it while held.
  assign ImemReq   = (state == S_REQ) && !reset;
  assign ImemAddr  = fpc;
  assign PCPlus4F  = PCF + PC_STEP;
  assign slot_free = !InstrValidF || !StallF;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_REQ;
      fpc         <= RESET_PC;
      InstrF      <= NOP_INSTR;
      InstrValidF <= 1'b0;
      PCF         <= RESET_PC;
      sk_instr    <= NOP_INSTR;
      sk_pc       <= RESET_PC;
      sk_v        <= 1'b0;
    end else if (BranchTakenE) begin
      fpc         <= BranchTargetE;
      InstrF      <= NOP_INSTR;
      InstrValidF <= 1'b0;
      sk_v        <= 1'b0;
      case (state)
        S_REQ:   state <= ImemGnt    ? S_DRAIN : S_REQ;
        S_WAIT:  state <= ImemRValid ? S_REQ   : S_DRAIN;
        S_FULL:  state <= S_REQ;
        default: state <= S_DRAIN;
      endcase
    end else begin
      // Slot consumed with nothing new behind it drops to a bubble.
      if (InstrValidF && !StallF) begin
        InstrValidF <= 1'b0;
        InstrF      <= NOP_INSTR;
      end
      case (state)
        S_REQ: if (ImemGnt) state <= S_WAIT;
        S_WAIT: if (ImemRValid) begin
          fpc <= fpc + PC_STEP;
          if (slot_free) begin
            InstrF      <= ImemRData;
            PCF         <= fpc;
            InstrValidF <= 1'b1;
            state       <= S_REQ;
          end else begin
            sk_instr <= ImemRData;
            sk_pc    <= fpc;
            sk_v     <= 1'b1;
            state    <= S_FULL;
          end
        end
        S_FULL: if (!StallF) begin
          InstrF      <= sk_instr;
          PCF         <= sk_pc;
          InstrValidF <= 1'b1;
          sk_v        <= 1'b0;
          state       <= S_REQ;
        end
        default: if (ImemRValid) state <= S_REQ;
      endcase
    end
  end

endmodule
